// File: rtl/jogador_pkg.sv
// Shared definitions for the automatic memory-game player: state encodings,
// default sequence depth and the press-corruption helper.
package jogador_pkg;

  typedef logic [3:0] estado_t;

  localparam logic [3:0] INICIAL   = 4'd0;
  localparam logic [3:0] PEDE_JOGO = 4'd1;
  localparam logic [3:0] OBSERVA   = 4'd2;
  localparam logic [3:0] PRESSIONA = 4'd3;
  localparam logic [3:0] SOLTA     = 4'd4;
  localparam logic [3:0] PROXIMA   = 4'd5;
  localparam logic [3:0] FIM       = 4'd15;

  localparam int N_MAX_PADRAO = 16;
  localparam int BOTOES_W     = 4;

  // Rotate a 4-bit button value left by one; turns any one-hot press into a
  // different one-hot press, which the game must reject.
  function automatic logic [3:0] rot_esq4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/jogador_automatico_memoria.sv
// Sequence store for the automatic player: N_MAX entries of DATA_W bits,
// written synchronously while observing, read asynchronously while replaying.
module memoria_sequencia
  import jogador_pkg::*;
#(
  parameter int N_MAX  = N_MAX_PADRAO,
  parameter int DATA_W = BOTOES_W,
  parameter int AW     = (N_MAX > 1) ? $clog2(N_MAX) : 1
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [N_MAX];

  // Contents carry data only, so they are never reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: requests a game, records the LED
// sequence of each round and replays it on the buttons with fixed press/gap
// timing, optionally corrupting one chosen press.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int N_MAX        = N_MAX_PADRAO,
  parameter int JOGAR_CYCLES = 5,
  parameter int PRESS_CYCLES = 5,
  parameter int GAP_CYCLES   = 510,
  parameter int QUIET_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  input  logic       erro_en,
  input  logic [3:0] erro_rodada,
  input  logic [3:0] erro_jogada,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic [3:0] db_rodada,
  output logic [3:0] db_jogada,
  output logic [3:0] db_estado
);

  // Address width of the store (jogada is 4 bits, so N_MAX is at most 16),
  // width of the length counter (must hold N_MAX itself) and timer width
  // covering the longest of the four timed intervals.
  localparam int AW      = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int CW      = $clog2(N_MAX + 1);
  localparam int MAX_AB  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int MAX_CD  = (QUIET_CYCLES > JOGAR_CYCLES) ? QUIET_CYCLES : JOGAR_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW      = $clog2(MAX_CYC + 1);

  estado_t       estado, estado_prox;
  logic [TW-1:0] timer, timer_prox;
  logic [CW-1:0] comprimento, comprimento_prox;
  logic [3:0]    jogada, jogada_prox;
  logic [3:0]    rodada, rodada_prox;
  logic [3:0]    leds_ant;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_dout;

  logic          evento;
  logic          abortar;
  logic          corromper;
  logic [3:0]    valor_press;

  memoria_sequencia #(
    .N_MAX  (N_MAX),
    .DATA_W (4),
    .AW     (AW)
  ) u_memoria (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .din   (leds),
    .dout  (mem_dout)
  );

  // Writes only happen while observing, reads only while replaying, so one
  // address port is shared between the length and replay counters.
  assign mem_addr = (estado == OBSERVA) ? comprimento[AW-1:0] : jogada[AW-1:0];

  // A flash starts when the LEDs leave the all-dark value.
  assign evento = (leds_ant == 4'd0) && (leds != 4'd0);

  // A result flag from the game ends any active game, whatever we are doing.
  assign abortar = (ganhou || perdeu) && (estado != INICIAL) && (estado != FIM);

  assign corromper   = erro_en && (rodada == erro_rodada) && (jogada == erro_jogada);
  assign valor_press = corromper ? rot_esq4(mem_dout) : mem_dout;

  // Next-state, counter and timer logic; the shared timer restarts on every
  // state change.
  always_comb begin
    estado_prox      = estado;
    timer_prox       = timer + TW'(1);
    comprimento_prox = comprimento;
    jogada_prox      = jogada;
    rodada_prox      = rodada;
    mem_we           = 1'b0;

    case (estado)
      INICIAL, FIM: begin
        if (iniciar) begin
          estado_prox      = PEDE_JOGO;
          rodada_prox      = 4'd0;
          jogada_prox      = 4'd0;
          comprimento_prox = '0;
        end
      end

      PEDE_JOGO: begin
        if (timer == TW'(JOGAR_CYCLES - 1)) begin
          estado_prox = OBSERVA;
        end
      end

      OBSERVA: begin
        if (evento && (comprimento < CW'(N_MAX))) begin
          mem_we           = 1'b1;
          comprimento_prox = comprimento + CW'(1);
        end
        if (leds != 4'd0) begin
          timer_prox = '0;
        end else if (comprimento == '0) begin
          // Nothing seen yet: wait for the first flash without a timeout.
          timer_prox = '0;
        end else if (timer == TW'(QUIET_CYCLES - 1)) begin
          estado_prox = PRESSIONA;
          jogada_prox = 4'd0;
        end
      end

      PRESSIONA: begin
        if (timer == TW'(PRESS_CYCLES - 1)) begin
          estado_prox = SOLTA;
        end
      end

      SOLTA: begin
        if (timer == TW'(GAP_CYCLES - 1)) begin
          estado_prox = PROXIMA;
        end
      end

      PROXIMA: begin
        if ((CW'(jogada) + CW'(1)) < comprimento) begin
          jogada_prox = jogada + 4'd1;
          estado_prox = PRESSIONA;
        end else begin
          rodada_prox      = rodada + 4'd1;
          comprimento_prox = '0;
          jogada_prox      = 4'd0;
          estado_prox      = OBSERVA;
        end
      end

      default: begin
        estado_prox = INICIAL;
      end
    endcase

    // Abort wins over everything; counters are frozen for debug.
    if (abortar) begin
      estado_prox      = FIM;
      comprimento_prox = comprimento;
      jogada_prox      = jogada;
      rodada_prox      = rodada;
      mem_we           = 1'b0;
    end

    if (estado_prox != estado) begin
      timer_prox = '0;
    end
  end

  // State, counters and registered outputs; an abort or reset clears the
  // buttons at the same edge so no partial press survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= INICIAL;
      timer       <= '0;
      comprimento <= '0;
      jogada      <= 4'd0;
      rodada      <= 4'd0;
      leds_ant    <= 4'd0;
      jogar       <= 1'b0;
      botoes      <= 4'd0;
      ocupado     <= 1'b0;
    end else begin
      estado      <= estado_prox;
      timer       <= timer_prox;
      comprimento <= comprimento_prox;
      jogada      <= jogada_prox;
      rodada      <= rodada_prox;
      leds_ant    <= leds;
      jogar       <= (estado == PEDE_JOGO) && !abortar;
      botoes      <= ((estado == PRESSIONA) && !abortar) ? valor_press : 4'd0;
      ocupado     <= (estado_prox != INICIAL) && (estado_prox != FIM);
    end
  end

  assign db_estado = estado;
  assign db_rodada = rodada;
  assign db_jogada = jogada;

endmodule
